// File: rtl/halut_matmul_ctrl.sv
// halut_matmul_ctrl
// Sequencer for the HALUT matmul array. It streams one 16-bit configuration
// word stream into the encoder threshold memories and then into the decoder
// LUT memories. It then enables the encoder until rows*DecoderUnits decoder
// results have been counted, and pulses done_o.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_i/reload_i/n_rows_i  job start (IDLE only), reload select, row count
//   abort_i                    synchronous return to IDLE, counters cleared
//   cfg_valid_i/cfg_ready_o/cfg_data_i   configuration word handshake
//   waddr_enc_o/wdata_enc_o/we_enc_o     per encoder unit threshold write port
//   encoder_o                  encoder enable (RUN)
//   m_addr_dec_o/waddr_dec_o/wdata_dec_o/we_dec_o  per decoder-X LUT write port
//   res_valid_i                valid_o[0] of the matmul top
//   busy_o, done_o             status; done_o is a one-cycle pulse
//   run_cycles_o               RUN-state cycle count
//
// Optional feature macro: HALUT_CTRL_PERF_CNT_EN
//   defined   -> saturating 32-bit RUN cycle counter on run_cycles_o
//   undefined -> run_cycles_o tied to 0
module halut_matmul_ctrl #(
  parameter int K                  = 16,
  parameter int C                  = 32,
  parameter int M                  = 32,
  parameter int DecoderUnits       = 16,
  parameter int EncUnits           = 4,
  parameter int DataTypeWidth      = 16,
  parameter int RowWidth           = 16,
  parameter int DecUnitsX          = M / DecoderUnits,
  parameter int CPerEncUnit        = C / EncUnits,
  parameter int EncWords           = C * K,
  parameter int ThreshMemAddrWidth = $clog2(CPerEncUnit * K),
  parameter int TotalAddrWidth     = $clog2(C * K),
  parameter int DecAddrWidth       = $clog2(DecoderUnits)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          reload_i,
  input  logic [RowWidth-1:0]           n_rows_i,
  input  logic                          abort_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [15:0]                   cfg_data_i,
  output logic [ThreshMemAddrWidth-1:0] waddr_enc_o [EncUnits],
  output logic [15:0]                   wdata_enc_o [EncUnits],
  output logic                          we_enc_o    [EncUnits],
  output logic                          encoder_o,
  output logic [DecAddrWidth-1:0]       m_addr_dec_o [DecUnitsX],
  output logic [TotalAddrWidth-1:0]     waddr_dec_o  [DecUnitsX],
  output logic [DataTypeWidth-1:0]      wdata_dec_o  [DecUnitsX],
  output logic                          we_dec_o     [DecUnitsX],
  input  logic                          res_valid_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [31:0]                   run_cycles_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_ENC = 3'd1;
  localparam logic [2:0] S_LOAD_DEC = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam int EncUnitW = (EncUnits > 1) ? $clog2(EncUnits) : 1;
  localparam int DecXW    = (DecUnitsX > 1) ? $clog2(DecUnitsX) : 1;

  localparam logic [TotalAddrWidth-1:0]     EncCntLast  = TotalAddrWidth'(EncWords - 1);
  localparam logic [ThreshMemAddrWidth-1:0] EncAddrLast = ThreshMemAddrWidth'(CPerEncUnit * K - 1);
  localparam logic [TotalAddrWidth-1:0]     DecAddrLast = TotalAddrWidth'(C * K - 1);
  localparam logic [DecAddrWidth-1:0]       DecMLast    = DecAddrWidth'(DecoderUnits - 1);
  localparam logic [DecXW-1:0]              DecXLast    = DecXW'(DecUnitsX - 1);

  logic [2:0]                    state_r;
  logic [2:0]                    state_next_s;
  logic [RowWidth-1:0]           rows_r;
  logic [TotalAddrWidth-1:0]     enc_cnt_r;
  logic [ThreshMemAddrWidth-1:0] enc_addr_r;
  logic [EncUnitW-1:0]           enc_unit_r;
  logic [TotalAddrWidth-1:0]     dec_addr_r;
  logic [DecAddrWidth-1:0]       dec_m_r;
  logic [DecXW-1:0]              dec_x_r;
  logic [31:0]                   res_cnt_r;
  logic [31:0]                   res_target_s;
  logic                          cfg_ready_s;
  logic                          enc_accept_s;
  logic                          dec_accept_s;
  logic                          enc_last_s;
  logic                          dec_last_s;
  logic                          res_last_s;
  logic                          start_ok_s;

  // Status outputs are pure decodes of the registered state.
  assign cfg_ready_s = (state_r == S_LOAD_ENC) || (state_r == S_LOAD_DEC);
  assign cfg_ready_o = cfg_ready_s;
  assign encoder_o   = (state_r == S_RUN);
  assign busy_o      = (state_r != S_IDLE);
  assign done_o      = (state_r == S_DONE);

  assign start_ok_s   = (state_r == S_IDLE) && start_i;
  assign enc_accept_s = cfg_valid_i && (state_r == S_LOAD_ENC);
  assign dec_accept_s = cfg_valid_i && (state_r == S_LOAD_DEC);
  assign enc_last_s   = (enc_cnt_r == EncCntLast);
  assign dec_last_s   = (dec_addr_r == DecAddrLast) && (dec_m_r == DecMLast) && (dec_x_r == DecXLast);
  // Full 32-bit product so a large row count cannot wrap the target.
  assign res_target_s = 32'(rows_r) * 32'(DecoderUnits);
  assign res_last_s   = res_valid_i && ((res_cnt_r + 32'd1) == res_target_s);

  // Next-state selection; abort overrides everything including a same-cycle start.
  always_comb begin
    state_next_s = state_r;
    if (abort_i) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            if (reload_i) begin
              state_next_s = S_LOAD_ENC;
            end else if (n_rows_i == '0) begin
              state_next_s = S_DONE;
            end else begin
              state_next_s = S_RUN;
            end
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_LOAD_ENC: begin
          if (enc_accept_s && enc_last_s) begin
            state_next_s = S_LOAD_DEC;
          end else begin
            state_next_s = S_LOAD_ENC;
          end
        end
        S_LOAD_DEC: begin
          if (dec_accept_s && dec_last_s) begin
            state_next_s = (rows_r == '0) ? S_DONE : S_RUN;
          end else begin
            state_next_s = S_LOAD_DEC;
          end
        end
        S_RUN: begin
          if (res_last_s) begin
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_RUN;
          end
        end
        S_DONE:  state_next_s = S_IDLE;
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Row latch plus word and result counters; unit/address counters walk the
  // memory map directly so no divide is needed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rows_r     <= '0;
      enc_cnt_r  <= '0;
      enc_addr_r <= '0;
      enc_unit_r <= '0;
      dec_addr_r <= '0;
      dec_m_r    <= '0;
      dec_x_r    <= '0;
      res_cnt_r  <= 32'd0;
    end else if (abort_i || start_ok_s) begin
      if (!abort_i) begin
        rows_r <= n_rows_i;
      end
      enc_cnt_r  <= '0;
      enc_addr_r <= '0;
      enc_unit_r <= '0;
      dec_addr_r <= '0;
      dec_m_r    <= '0;
      dec_x_r    <= '0;
      res_cnt_r  <= 32'd0;
    end else begin
      if (enc_accept_s) begin
        enc_cnt_r <= enc_cnt_r + TotalAddrWidth'(1);
        if (enc_addr_r == EncAddrLast) begin
          enc_addr_r <= '0;
          enc_unit_r <= enc_unit_r + EncUnitW'(1);
        end else begin
          enc_addr_r <= enc_addr_r + ThreshMemAddrWidth'(1);
        end
      end
      if (dec_accept_s) begin
        if (dec_addr_r == DecAddrLast) begin
          dec_addr_r <= '0;
          if (dec_m_r == DecMLast) begin
            dec_m_r <= '0;
            dec_x_r <= dec_x_r + DecXW'(1);
          end else begin
            dec_m_r <= dec_m_r + DecAddrWidth'(1);
          end
        end else begin
          dec_addr_r <= dec_addr_r + TotalAddrWidth'(1);
        end
      end
      if ((state_r == S_RUN) && res_valid_i) begin
        res_cnt_r <= res_cnt_r + 32'd1;
      end
    end
  end

  // Registered memory write ports: an accepted word shows up one cycle later
  // on exactly one enable; other units keep their last address/data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int u = 0; u < EncUnits; u++) begin
        we_enc_o[u]    <= 1'b0;
        waddr_enc_o[u] <= '0;
        wdata_enc_o[u] <= 16'd0;
      end
      for (int x = 0; x < DecUnitsX; x++) begin
        we_dec_o[x]     <= 1'b0;
        m_addr_dec_o[x] <= '0;
        waddr_dec_o[x]  <= '0;
        wdata_dec_o[x]  <= '0;
      end
    end else begin
      for (int u = 0; u < EncUnits; u++) begin
        we_enc_o[u] <= 1'b0;
      end
      for (int x = 0; x < DecUnitsX; x++) begin
        we_dec_o[x] <= 1'b0;
      end
      if (enc_accept_s) begin
        we_enc_o[enc_unit_r]    <= 1'b1;
        waddr_enc_o[enc_unit_r] <= enc_addr_r;
        wdata_enc_o[enc_unit_r] <= cfg_data_i;
      end
      if (dec_accept_s) begin
        we_dec_o[dec_x_r]     <= 1'b1;
        m_addr_dec_o[dec_x_r] <= dec_m_r;
        waddr_dec_o[dec_x_r]  <= dec_addr_r;
        wdata_dec_o[dec_x_r]  <= cfg_data_i[DataTypeWidth-1:0];
      end
    end
  end

`ifdef HALUT_CTRL_PERF_CNT_EN
  logic [31:0] run_cycles_r;

  // RUN cycle counter: cleared when a job starts, saturates at all-ones,
  // then holds until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cycles_r <= 32'd0;
    end else if (abort_i || start_ok_s) begin
      run_cycles_r <= 32'd0;
    end else if ((state_r == S_RUN) && (run_cycles_r != 32'hFFFF_FFFF)) begin
      run_cycles_r <= run_cycles_r + 32'd1;
    end else begin
      run_cycles_r <= run_cycles_r;
    end
  end

  assign run_cycles_o = run_cycles_r;
`else
  assign run_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_halut_matmul_ctrl.sv
module tb_halut_matmul_ctrl;
  localparam int K = 4, C = 8, M = 8, DU = 4, EU = 4, DTW = 16, RW = 16;
  localparam int DUX = M / DU, CPE = C / EU, ENC_PER = CPE * K;
  localparam int ENC_WORDS = C * K, LUT_WORDS = M * C * K;
  localparam int TMAW = $clog2(ENC_PER), TAW = $clog2(C * K), DAW = $clog2(DU);
`ifdef HALUT_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0, rst_ni = 1'b0;
  logic start = 1'b0, reload = 1'b0, abort = 1'b0, cfg_valid = 1'b0, res_valid = 1'b0;
  logic [RW-1:0] n_rows = '0;
  logic [15:0] cfg_data = 16'd0;
  logic cfg_ready, encoder, busy, done;
  logic [31:0] run_cycles;
  logic [TMAW-1:0] waddr_enc [EU];
  logic [15:0]     wdata_enc [EU];
  logic            we_enc    [EU];
  logic [DAW-1:0]  m_addr_dec [DUX];
  logic [TAW-1:0]  waddr_dec  [DUX];
  logic [DTW-1:0]  wdata_dec  [DUX];
  logic            we_dec     [DUX];

  halut_matmul_ctrl #(.K(K), .C(C), .M(M), .DecoderUnits(DU), .EncUnits(EU),
                      .DataTypeWidth(DTW), .RowWidth(RW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .reload_i(reload), .n_rows_i(n_rows),
    .abort_i(abort), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_data_i(cfg_data),
    .waddr_enc_o(waddr_enc), .wdata_enc_o(wdata_enc), .we_enc_o(we_enc), .encoder_o(encoder),
    .m_addr_dec_o(m_addr_dec), .waddr_dec_o(waddr_dec), .wdata_dec_o(wdata_dec), .we_dec_o(we_dec),
    .res_valid_i(res_valid), .busy_o(busy), .done_o(done), .run_cycles_o(run_cycles));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int idx; int m; int addr; int data; int cyc; } wr_t;
  typedef struct { int cyc; int rc; } dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference memory map for accepted word i (threshold words first, then LUT words).
  function automatic wr_t ref_word(input int i, input int data, input int c);
    wr_t w;
    int j;
    w.data = data;
    w.cyc  = c;
    if (i < ENC_WORDS) begin
      w.kind = 0; w.idx = i / ENC_PER; w.m = 0; w.addr = i % ENC_PER;
    end else begin
      j = i - ENC_WORDS;
      w.kind = 1; w.idx = j / (DU * C * K); w.m = (j / (C * K)) % DU; w.addr = j % (C * K);
      w.data = data & ((1 << DTW) - 1);
    end
    return w;
  endfunction

  // Monitor: every write enable and done pulse is matched against the scoreboard.
  wr_t mon_e;
  dn_t mon_d;
  int  mon_nwe;
  always @(negedge clk) begin
    if (rst_ni) begin
      mon_nwe = 0;
      for (int u = 0; u < EU; u++) begin
        if (we_enc[u]) begin
          mon_nwe++;
          chk("enc_we_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            mon_e = exp_wr.pop_front();
            chk("enc_kind", 0, mon_e.kind);
            chk("enc_unit", u, mon_e.idx);
            chk("enc_addr", waddr_enc[u], mon_e.addr);
            chk("enc_data", wdata_enc[u], mon_e.data);
            chk("enc_cycle", cyc, mon_e.cyc);
          end
        end
      end
      for (int x = 0; x < DUX; x++) begin
        if (we_dec[x]) begin
          mon_nwe++;
          chk("dec_we_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            mon_e = exp_wr.pop_front();
            chk("dec_kind", 1, mon_e.kind);
            chk("dec_x", x, mon_e.idx);
            chk("dec_m", m_addr_dec[x], mon_e.m);
            chk("dec_addr", waddr_dec[x], mon_e.addr);
            chk("dec_data", wdata_dec[x], mon_e.data);
            chk("dec_cycle", cyc, mon_e.cyc);
          end
        end
      end
      if (mon_nwe != 0) chk("we_onehot", mon_nwe, 1);
      if (done) begin
        chk("done_expected", exp_dn.size() > 0, 1);
        if (exp_dn.size() > 0) begin
          mon_d = exp_dn.pop_front();
          chk("done_cycle", cyc, mon_d.cyc);
          chk("run_cycles", run_cycles, mon_d.rc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic rl, input int rows);
    start = 1'b1; reload = rl; n_rows = RW'(rows);
    tick();
    start = 1'b0; reload = 1'b0;
  endtask

  task automatic load(input bit gaps, input int nwords);
    int sent;
    int slot;
    sent = 0; slot = 0;
    while (sent < nwords) begin
      chk("cfg_ready_load", cfg_ready, 1);
      cfg_data = 16'($urandom);
      if (!gaps || (slot % 2 == 0)) begin
        cfg_valid = 1'b1;
        exp_wr.push_back(ref_word(sent, int'(cfg_data), cyc + 1));
        sent++;
      end else begin
        cfg_valid = 1'b0;
      end
      slot++;
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  // Current slot must be the first RUN cycle; result k is pulsed at RUN slot first+k*spacing.
  task automatic run(input int rows, input int first, input int spacing, input bit poke_start);
    int total;
    int slot_i;
    dn_t d;
    total = rows * DU; slot_i = 0;
    chk("encoder_run_entry", encoder, 1);
    chk("cfg_ready_in_run", cfg_ready, 0);
    if (poke_start) begin start = 1'b1; reload = 1'b1; n_rows = RW'(1); end
    for (int k = 0; k < total; k++) begin
      while (slot_i < first + k * spacing) begin
        tick(); slot_i++; start = 1'b0; reload = 1'b0;
      end
      chk("encoder_in_run", encoder, 1);
      res_valid = 1'b1;
      if (k == total - 1) begin
        d.cyc = cyc + 1;
        d.rc  = PERF ? slot_i + 1 : 0;
        exp_dn.push_back(d);
      end
      tick(); slot_i++; start = 1'b0; reload = 1'b0;
      res_valid = 1'b0;
    end
    chk("encoder_after_last", encoder, 0);
    chk("busy_in_done", busy, 1);
    tick();
    chk("busy_back_idle", busy, 0);
    chk("done_seen", exp_dn.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    dn_t d;
    // Reset values.
    repeat (3) tick();
    chk("rst_busy", busy, 0); chk("rst_ready", cfg_ready, 0);
    chk("rst_encoder", encoder, 0); chk("rst_done", done, 0);
    chk("rst_run_cycles", run_cycles, 0);
    for (int u = 0; u < EU; u++) begin
      chk("rst_we_enc", we_enc[u], 0); chk("rst_waddr_enc", waddr_enc[u], 0);
      chk("rst_wdata_enc", wdata_enc[u], 0);
    end
    for (int x = 0; x < DUX; x++) begin
      chk("rst_we_dec", we_dec[x], 0); chk("rst_m_addr", m_addr_dec[x], 0);
      chk("rst_waddr_dec", waddr_dec[x], 0); chk("rst_wdata_dec", wdata_dec[x], 0);
    end
    rst_ni = 1'b1;
    tick();

    // Config words and results in IDLE are ignored.
    cfg_valid = 1'b1; res_valid = 1'b1; cfg_data = 16'hBEEF;
    repeat (3) begin tick(); chk("idle_ready", cfg_ready, 0); chk("idle_busy", busy, 0); end
    cfg_valid = 1'b0; res_valid = 1'b0;
    tick();

    // Full load without gaps, 2 rows.
    do_start(1'b1, 2);
    load(1'b0, ENC_WORDS + LUT_WORDS);
    run(2, 0, $urandom_range(1, 3), 1'b0);

    // Load with valid toggling every other cycle, 1 row.
    do_start(1'b1, 1);
    load(1'b1, ENC_WORDS + LUT_WORDS);
    run(1, $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);

    // Reuse contents, 3 rows, with a start pulse while busy.
    do_start(1'b0, 3);
    run(3, 1, $urandom_range(1, 3), 1'b1);

    // Zero rows without reload: DONE straight after start.
    d.cyc = cyc + 1; d.rc = 0;
    exp_dn.push_back(d);
    do_start(1'b0, 0);
    chk("zero_rows_encoder", encoder, 0); chk("zero_rows_busy", busy, 1);
    tick();
    chk("zero_rows_encoder_after", encoder, 0); chk("zero_rows_idle", busy, 0);
    chk("zero_rows_done_seen", exp_dn.size(), 0);

    // Abort after 100 LUT words.
    do_start(1'b1, 1);
    load(1'b0, ENC_WORDS + 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", cfg_ready, 0); chk("abort_busy", busy, 0);
    repeat (2) tick();

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1; start = 1'b1; reload = 1'b1; n_rows = RW'(1);
    tick();
    abort = 1'b0; start = 1'b0; reload = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick();

    // Restart after abort begins again at threshold word 0.
    do_start(1'b1, 1);
    load(1'b0, ENC_WORDS + LUT_WORDS);
    run(1, 0, 1, 1'b0);

    // Run-cycle counter: 2 rows, results 5 cycles apart.
    do_start(1'b0, 2);
    run(2, 4, 5, 1'b0);
    tick();
    chk("run_cycles_hold", run_cycles, PERF ? 40 : 0);

    // Asynchronous reset in the middle of a threshold load.
    do_start(1'b1, 1);
    load(1'b0, 10);
    tick();
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0); chk("async_rst_ready", cfg_ready, 0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    repeat (3) tick();
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("done_queue_drained", exp_dn.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
